// File: rtl/pci_cfgspace.sv
// PCI type-0 configuration header: fixed ID/class registers, Command/Status,
// BAR0, cache/latency and interrupt line, with registered read data.
module pci_cfgspace #(
    parameter logic [15:0] VENDOR_ID      = 16'h1234,
    parameter logic [15:0] DEVICE_ID      = 16'h11E8,
    parameter logic [31:0] CLASS_REV      = 32'h00FF0010,
    parameter logic [31:0] SUBSYS_ID      = 32'h11001AF4,
    parameter int unsigned BAR0_SIZE_LOG2 = 12,
    parameter logic [7:0]  INT_PIN        = 8'h01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_enable,
    input  logic        cfg_iswrite,
    input  logic [5:0]  cfg_offset,
    input  logic [31:0] cfg_write_val,
    input  logic [3:0]  cfg_byte_en,
    output logic [31:0] cfg_read_val,
    input  logic        intx_pending,
    input  logic        evt_parity_err,
    input  logic        evt_sys_err,
    input  logic        evt_tgt_abort,
    output logic        cmd_io_en,
    output logic        cmd_mem_en,
    output logic        cmd_bus_master,
    output logic [31:0] bar0_base,
    output logic [7:0]  int_line,
    output logic        int_assert
);

    localparam logic [15:0] CMD_MASK  = 16'h0547;
    localparam logic [31:0] BAR0_MASK = 32'hFFFF_FFFF << BAR0_SIZE_LOG2;

    logic [15:0] cmd_q, cmd_d;
    logic        perr_q, perr_d;
    logic        serr_q, serr_d;
    logic        tabt_q, tabt_d;
    logic [7:0]  lat_q, lat_d;
    logic [7:0]  cls_q, cls_d;
    logic [31:0] bar0_q, bar0_d;
    logic [7:0]  int_line_q, int_line_d;
    logic [31:0] rd_q, rd_d;

    logic [31:0] lane_mask;
    logic [31:0] rdata;
    logic        wr_en;
    logic        rd_en;

    assign wr_en = cfg_enable & cfg_iswrite;
    assign rd_en = cfg_enable & ~cfg_iswrite;

    always_comb begin
        lane_mask = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            lane_mask[8*i +: 8] = {8{cfg_byte_en[i]}};
        end
    end

    always_comb begin
        rdata = '0;
        case (cfg_offset)
            6'h00: rdata = {DEVICE_ID, VENDOR_ID};
            6'h01: rdata = {perr_q, serr_q, 2'b00, tabt_q, 7'b0, intx_pending, 3'b000, cmd_q};
            6'h02: rdata = CLASS_REV;
            6'h03: rdata = {16'h0000, lat_q, cls_q};
            6'h04: rdata = bar0_q;
            6'h0B: rdata = SUBSYS_ID;
            6'h0F: rdata = {16'h0000, INT_PIN, int_line_q};
            default: rdata = '0;
        endcase
    end

    always_comb begin
        cmd_d      = cmd_q;
        perr_d     = perr_q;
        serr_d     = serr_q;
        tabt_d     = tabt_q;
        lat_d      = lat_q;
        cls_d      = cls_q;
        bar0_d     = bar0_q;
        int_line_d = int_line_q;
        rd_d       = rd_q;

        if (rd_en) begin
            rd_d = rdata;
        end

        if (wr_en) begin
            case (cfg_offset)
                6'h01: begin
                    cmd_d = (cmd_q & ~(lane_mask[15:0] & CMD_MASK))
                          | (cfg_write_val[15:0] & lane_mask[15:0] & CMD_MASK);
                    if (cfg_byte_en[3]) begin
                        perr_d = perr_q & ~cfg_write_val[31];
                        serr_d = serr_q & ~cfg_write_val[30];
                        tabt_d = tabt_q & ~cfg_write_val[27];
                    end
                end
                6'h03: begin
                    if (cfg_byte_en[0]) cls_d = cfg_write_val[7:0];
                    if (cfg_byte_en[1]) lat_d = cfg_write_val[15:8];
                end
                6'h04: begin
                    bar0_d = (bar0_q & ~(lane_mask & BAR0_MASK))
                           | (cfg_write_val & lane_mask & BAR0_MASK);
                end
                6'h0F: begin
                    if (cfg_byte_en[0]) int_line_d = cfg_write_val[7:0];
                end
                default: ;
            endcase
        end

        // Events applied after the W1C clear so a coincident set wins.
        if (evt_parity_err) perr_d = 1'b1;
        if (evt_sys_err)    serr_d = 1'b1;
        if (evt_tgt_abort)  tabt_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd_q      <= '0;
            perr_q     <= 1'b0;
            serr_q     <= 1'b0;
            tabt_q     <= 1'b0;
            lat_q      <= '0;
            cls_q      <= '0;
            bar0_q     <= '0;
            int_line_q <= '0;
            rd_q       <= '0;
        end else begin
            cmd_q      <= cmd_d;
            perr_q     <= perr_d;
            serr_q     <= serr_d;
            tabt_q     <= tabt_d;
            lat_q      <= lat_d;
            cls_q      <= cls_d;
            bar0_q     <= bar0_d;
            int_line_q <= int_line_d;
            rd_q       <= rd_d;
        end
    end

    assign cfg_read_val   = rd_q;
    assign cmd_io_en      = cmd_q[0];
    assign cmd_mem_en     = cmd_q[1];
    assign cmd_bus_master = cmd_q[2];
    assign bar0_base      = bar0_q;
    assign int_line       = int_line_q;
    assign int_assert     = intx_pending & ~cmd_q[10];

endmodule

// File: tb/tb_pci_cfgspace.sv
// Directed checks of the pci_cfgspace header registers with immediate assertions.
module tb_pci_cfgspace;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_enable;
    logic        cfg_iswrite;
    logic [5:0]  cfg_offset;
    logic [31:0] cfg_write_val;
    logic [3:0]  cfg_byte_en;
    logic [31:0] cfg_read_val;
    logic        intx_pending;
    logic        evt_parity_err;
    logic        evt_sys_err;
    logic        evt_tgt_abort;
    logic        cmd_io_en;
    logic        cmd_mem_en;
    logic        cmd_bus_master;
    logic [31:0] bar0_base;
    logic [7:0]  int_line;
    logic        int_assert;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    pci_cfgspace #(
        .VENDOR_ID(16'h1234),
        .DEVICE_ID(16'h11E8),
        .CLASS_REV(32'h00FF0010),
        .SUBSYS_ID(32'h11001AF4),
        .BAR0_SIZE_LOG2(12),
        .INT_PIN(8'h01)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cfg_enable(cfg_enable),
        .cfg_iswrite(cfg_iswrite),
        .cfg_offset(cfg_offset),
        .cfg_write_val(cfg_write_val),
        .cfg_byte_en(cfg_byte_en),
        .cfg_read_val(cfg_read_val),
        .intx_pending(intx_pending),
        .evt_parity_err(evt_parity_err),
        .evt_sys_err(evt_sys_err),
        .evt_tgt_abort(evt_tgt_abort),
        .cmd_io_en(cmd_io_en),
        .cmd_mem_en(cmd_mem_en),
        .cmd_bus_master(cmd_bus_master),
        .bar0_base(bar0_base),
        .int_line(int_line),
        .int_assert(int_assert)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic access(input logic wr, input logic [5:0] off,
                          input logic [31:0] val, input logic [3:0] be);
        @(negedge clk);
        cfg_enable    = 1'b1;
        cfg_iswrite   = wr;
        cfg_offset    = off;
        cfg_write_val = val;
        cfg_byte_en   = be;
        @(posedge clk);
        #1;
        cfg_enable    = 1'b0;
        cfg_iswrite   = 1'b0;
    endtask

    task automatic rd(input logic [5:0] off);
        access(1'b0, off, 32'h0, 4'h0);
    endtask

    task automatic wr(input logic [5:0] off, input logic [31:0] val, input logic [3:0] be);
        access(1'b1, off, val, be);
    endtask

    initial begin
        rst            = 1'b0;
        cfg_enable     = 1'b0;
        cfg_iswrite    = 1'b0;
        cfg_offset     = '0;
        cfg_write_val  = '0;
        cfg_byte_en    = '0;
        intx_pending   = 1'b0;
        evt_parity_err = 1'b0;
        evt_sys_err    = 1'b0;
        evt_tgt_abort  = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_read_val", cfg_read_val, 32'h0);
        check("reset_bar0", bar0_base, 32'h0);
        check("reset_cmd", {29'h0, cmd_bus_master, cmd_mem_en, cmd_io_en}, 32'h0);
        check("reset_int_line", {24'h0, int_line}, 32'h0);

        @(negedge clk);
        rst = 1'b1;

        rd(6'h00);
        check("id_read", cfg_read_val, 32'h11E81234);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("id_hold", cfg_read_val, 32'h11E81234);
        end

        wr(6'h04, 32'hFFFFFFFF, 4'hF);
        check("rd_unchanged_by_write", cfg_read_val, 32'h11E81234);
        check("bar0_out", bar0_base, 32'hFFFFF000);
        rd(6'h04);
        check("bar0_read", cfg_read_val, 32'hFFFFF000);
        wr(6'h04, 32'h00000000, 4'b1000);
        check("bar0_lane3", bar0_base, 32'h00FFF000);

        wr(6'h01, 32'h0000FFFF, 4'hF);
        rd(6'h01);
        check("cmd_read", cfg_read_val, 32'h00000547);
        check("cmd_bits", {29'h0, cmd_bus_master, cmd_mem_en, cmd_io_en}, 32'h7);

        wr(6'h00, 32'hFFFFFFFF, 4'hF);
        rd(6'h00);
        check("id_readonly", cfg_read_val, 32'h11E81234);

        @(negedge clk);
        evt_sys_err = 1'b1;
        @(posedge clk);
        #1;
        evt_sys_err = 1'b0;
        rd(6'h01);
        check("serr_set", cfg_read_val, 32'h40000547);
        wr(6'h01, 32'h40000000, 4'b1000);
        rd(6'h01);
        check("serr_w1c", cfg_read_val, 32'h00000547);

        @(negedge clk);
        evt_sys_err   = 1'b1;
        cfg_enable    = 1'b1;
        cfg_iswrite   = 1'b1;
        cfg_offset    = 6'h01;
        cfg_write_val = 32'h40000000;
        cfg_byte_en   = 4'b1000;
        @(posedge clk);
        #1;
        evt_sys_err = 1'b0;
        cfg_enable  = 1'b0;
        cfg_iswrite = 1'b0;
        rd(6'h01);
        check("serr_set_wins", cfg_read_val, 32'h40000547);

        @(negedge clk);
        evt_parity_err = 1'b1;
        evt_tgt_abort  = 1'b1;
        @(posedge clk);
        #1;
        evt_parity_err = 1'b0;
        evt_tgt_abort  = 1'b0;
        rd(6'h01);
        check("status_all", cfg_read_val, 32'hC8000547);
        wr(6'h01, 32'hFFFFFFFF, 4'b1000);
        rd(6'h01);
        check("status_clear_all", cfg_read_val, 32'h00000547);

        wr(6'h0F, 32'hAABBCCDD, 4'b0001);
        rd(6'h0F);
        check("intline_read", cfg_read_val, 32'h000001DD);
        check("intline_out", {24'h0, int_line}, 32'h000000DD);

        wr(6'h03, 32'h12345678, 4'hF);
        rd(6'h03);
        check("lat_cls", cfg_read_val, 32'h00005678);

        wr(6'h05, 32'hFFFFFFFF, 4'hF);
        rd(6'h05);
        check("reserved_05", cfg_read_val, 32'h0);
        rd(6'h02);
        check("class_rev", cfg_read_val, 32'h00FF0010);
        rd(6'h0B);
        check("subsys", cfg_read_val, 32'h11001AF4);
        rd(6'h3F);
        check("reserved_3f", cfg_read_val, 32'h0);

        @(negedge clk);
        intx_pending = 1'b1;
        #1;
        check("int_masked", {31'h0, int_assert}, 32'h0);
        rd(6'h01);
        check("status_intx", cfg_read_val, 32'h00080547);
        wr(6'h01, 32'h00000147, 4'b0011);
        check("int_unmasked", {31'h0, int_assert}, 32'h1);
        rd(6'h01);
        check("cmd_bit10_clear", cfg_read_val, 32'h00080147);

        @(negedge clk);
        cfg_enable    = 1'b1;
        cfg_iswrite   = 1'b1;
        cfg_offset    = 6'h0F;
        cfg_write_val = 32'h000000FF;
        cfg_byte_en   = 4'b0001;
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        cfg_enable  = 1'b0;
        cfg_iswrite = 1'b0;
        check("rst_discard_intline", {24'h0, int_line}, 32'h0);
        check("rst_bar0", bar0_base, 32'h0);
        check("rst_read_val", cfg_read_val, 32'h0);
        check("rst_int_assert", {31'h0, int_assert}, 32'h1);

        @(negedge clk);
        rst           = 1'b1;
        cfg_enable    = 1'b1;
        cfg_iswrite   = 1'b0;
        cfg_offset    = 6'h00;
        @(posedge clk);
        #1;
        cfg_enable = 1'b0;
        check("first_strobe_after_rst", cfg_read_val, 32'h11E81234);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
